// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stage controller.
// Holds the FSM state enum, the per-stage en/clr bundle and the canned control patterns.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } state_t;

  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_TMO_W   = 5;
  localparam int DEF_CNT_W   = 32;

  typedef struct packed {
    logic en_f;
    logic en_d;
    logic clr_d;
    logic en_e;
    logic clr_e;
    logic en_m;
    logic clr_w;
  } stage_ctrl_t;

  // Field order: en_f, en_d, clr_d, en_e, clr_e, en_m, clr_w
  localparam stage_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam stage_ctrl_t CTRL_DBUSY  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam stage_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam stage_ctrl_t CTRL_HAZARD = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam stage_ctrl_t CTRL_IWAIT  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam stage_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline datapath / hazard unit (master) and the stage controller (slave).
// Handshake: a data access completes in the cycle dmem_req_m_i and dmem_ready_i are both high; req must stay high until then.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_ctrl_pkg::*;

  logic             hz_stall_i;
  logic             br_taken_e_i;
  logic             imem_ready_i;
  logic             dmem_req_m_i;
  logic             dmem_ready_i;

  logic             en_f_o;
  logic             en_d_o;
  logic             clr_d_o;
  logic             en_e_o;
  logic             clr_e_o;
  logic             en_m_o;
  logic             clr_w_o;
  logic             bus_err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  state_t           state_o;

  modport master (
    output hz_stall_i, br_taken_e_i, imem_ready_i, dmem_req_m_i, dmem_ready_i,
    input  en_f_o, en_d_o, clr_d_o, en_e_o, clr_e_o, en_m_o, clr_w_o,
    input  bus_err_o, stall_cnt_o, flush_cnt_o, state_o
  );

  modport slave (
    input  hz_stall_i, br_taken_e_i, imem_ready_i, dmem_req_m_i, dmem_ready_i,
    output en_f_o, en_d_o, clr_d_o, en_e_o, clr_e_o, en_m_o, clr_w_o,
    output bus_err_o, stall_cnt_o, flush_cnt_o, state_o
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      q_o <= '0;
    end else if (inc_i && (q_o != {W{1'b1}})) begin
      q_o <= q_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stage controller: merges load-use, branch, imem and dmem waits into per-stage en/clr,
// tracks data-memory waits with a timeout, and keeps saturating stall/flush counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMO_W   = DEF_TMO_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  pipeline_ctrl_if.slave bus
);

  state_t      state;
  logic [TMO_W-1:0] wait_cnt;
  logic        bus_err;
  logic        at_limit;
  logic        miss;
  logic        timeout;
  logic        dmem_busy;
  logic        stall_inc;
  logic        flush_inc;
  stage_ctrl_t ctrl;

  assign at_limit  = (state == DWAIT) && (wait_cnt == TMO_W'(TIMEOUT - 1));
  assign miss      = (state == RUN) && bus.dmem_req_m_i && !bus.dmem_ready_i;
  // A ready arriving on the last allowed cycle is a normal completion, not an error.
  assign timeout   = at_limit && !bus.dmem_ready_i;
  assign dmem_busy = miss || ((state == DWAIT) && !bus.dmem_ready_i && !at_limit);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= RUN;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (miss) begin
            state    <= DWAIT;
            wait_cnt <= '0;
          end
        end
        DWAIT: begin
          if (bus.dmem_ready_i || at_limit) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          if (timeout) begin
            bus_err <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl      = CTRL_RUN;
    flush_inc = 1'b0;
    if (!rst_n_i) begin
      ctrl = CTRL_RESET;
    end else if (dmem_busy) begin
      ctrl = CTRL_DBUSY;
    end else if (bus.br_taken_e_i) begin
      ctrl      = CTRL_BRANCH;
      flush_inc = 1'b1;
    end else if (bus.hz_stall_i) begin
      ctrl = CTRL_HAZARD;
    end else if (!bus.imem_ready_i) begin
      ctrl = CTRL_IWAIT;
    end
  end

  assign stall_inc = !ctrl.en_f;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (stall_inc),
    .q_o     (bus.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (flush_inc),
    .q_o     (bus.flush_cnt_o)
  );

  assign bus.en_f_o    = ctrl.en_f;
  assign bus.en_d_o    = ctrl.en_d;
  assign bus.clr_d_o   = ctrl.clr_d;
  assign bus.en_e_o    = ctrl.en_e;
  assign bus.clr_e_o   = ctrl.clr_e;
  assign bus.en_m_o    = ctrl.en_m;
  assign bus.clr_w_o   = ctrl.clr_w;
  assign bus.bus_err_o = bus_err;
  assign bus.state_o   = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a 16-cycle-timeout/32-bit instance and a 1-cycle-timeout/4-bit instance
// share stimulus; a behavioural model checks every cycle, plus a vector table and directed sequences.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hz = 1'b0, br = 1'b0, im = 1'b1, rq = 1'b0, rd = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(32)) if_a ();
  pipeline_ctrl_if #(.CNT_W(4))  if_b ();

  assign if_a.hz_stall_i   = hz;
  assign if_a.br_taken_e_i = br;
  assign if_a.imem_ready_i = im;
  assign if_a.dmem_req_m_i = rq;
  assign if_a.dmem_ready_i = rd;
  assign if_b.hz_stall_i   = hz;
  assign if_b.br_taken_e_i = br;
  assign if_b.imem_ready_i = im;
  assign if_b.dmem_req_m_i = rq;
  assign if_b.dmem_ready_i = rd;

  pipeline_ctrl #(.TIMEOUT(16), .TMO_W(5), .CNT_W(32)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if_a)
  );
  pipeline_ctrl #(.TIMEOUT(1), .TMO_W(1), .CNT_W(4)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if_b)
  );

  // Bit order {en_f, en_d, clr_d, en_e, clr_e, en_m, clr_w}
  localparam logic [6:0] P_RESET = 7'b0010101;
  localparam logic [6:0] P_DBUSY = 7'b0000001;
  localparam logic [6:0] P_BR    = 7'b1111110;
  localparam logic [6:0] P_HZ    = 7'b0001110;
  localparam logic [6:0] P_IWAIT = 7'b0111010;
  localparam logic [6:0] P_RUN   = 7'b1101010;

  logic [6:0]  act_ctrl [2];
  logic [63:0] act_stall[2];
  logic [63:0] act_flush[2];
  logic        act_err  [2];

  assign act_ctrl[0]  = {if_a.en_f_o, if_a.en_d_o, if_a.clr_d_o, if_a.en_e_o, if_a.clr_e_o, if_a.en_m_o, if_a.clr_w_o};
  assign act_ctrl[1]  = {if_b.en_f_o, if_b.en_d_o, if_b.clr_d_o, if_b.en_e_o, if_b.clr_e_o, if_b.en_m_o, if_b.clr_w_o};
  assign act_stall[0] = {32'd0, if_a.stall_cnt_o};
  assign act_stall[1] = {60'd0, if_b.stall_cnt_o};
  assign act_flush[0] = {32'd0, if_a.flush_cnt_o};
  assign act_flush[1] = {60'd0, if_b.flush_cnt_o};
  assign act_err[0]   = if_a.bus_err_o;
  assign act_err[1]   = if_b.bus_err_o;

  // Reference model: "waiting" flag plus number of wait cycles already spent
  int     tmo [2] = '{16, 1};
  longint cmax[2] = '{64'hFFFF_FFFF, 15};
  bit     m_wait  [2] = '{0, 0};
  int     m_waited[2] = '{0, 0};
  bit     m_err   [2] = '{0, 0};
  longint m_stall [2] = '{0, 0};
  longint m_flush [2] = '{0, 0};

  logic [6:0] e_ctrl  [2];
  bit         e_expire[2];
  bit         e_flush [2];
  bit         e_newmiss[2];
  bit         e_limit [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_eval(input int i);
    bit busy;
    e_newmiss[i] = rq && !rd && !m_wait[i];
    e_limit[i]   = m_wait[i] && (m_waited[i] == tmo[i] - 1);
    e_expire[i]  = e_limit[i] && !rd;
    busy         = e_newmiss[i] || (m_wait[i] && !rd && !e_limit[i]);
    e_flush[i]   = 1'b0;
    if (!rst_n)         e_ctrl[i] = P_RESET;
    else if (busy)      e_ctrl[i] = P_DBUSY;
    else if (br) begin  e_ctrl[i] = P_BR; e_flush[i] = 1'b1; end
    else if (hz)        e_ctrl[i] = P_HZ;
    else if (!im)       e_ctrl[i] = P_IWAIT;
    else                e_ctrl[i] = P_RUN;
  endfunction

  function automatic void model_update(input int i);
    if (!rst_n) begin
      m_wait[i] = 0; m_waited[i] = 0; m_err[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end else begin
      if (!e_ctrl[i][6] && m_stall[i] < cmax[i]) m_stall[i]++;
      if (e_flush[i] && m_flush[i] < cmax[i])   m_flush[i]++;
      if (e_expire[i]) m_err[i] = 1;
      if (e_newmiss[i]) begin
        m_wait[i] = 1; m_waited[i] = 0;
      end else if (m_wait[i]) begin
        if (rd || e_limit[i]) m_wait[i] = 0;
        else m_waited[i]++;
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      model_eval(i);
      chk($sformatf("model_ctrl[%0d]", i), {57'd0, act_ctrl[i]}, {57'd0, e_ctrl[i]});
      chk($sformatf("model_stall[%0d]", i), act_stall[i], m_stall[i]);
      chk($sformatf("model_flush[%0d]", i), act_flush[i], m_flush[i]);
      chk($sformatf("model_err[%0d]", i), {63'd0, act_err[i]}, {63'd0, m_err[i]});
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i);
    #1;
  endtask

  task automatic set_in(input bit h, input bit b, input bit i_r, input bit q, input bit r);
    hz = h; br = b; im = i_r; rq = q; rd = r;
  endtask

  task automatic do_reset();
    set_in(0, 0, 1, 0, 0);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("reset_ctrl", {57'd0, act_ctrl[0]}, {57'd0, P_RESET});
      tick();
    end
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    bit hz, br, im, rq, rd;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 0, 1, 0, 0, P_RUN};
    vecs[1]  = '{1, 0, 1, 0, 0, P_HZ};
    vecs[2]  = '{0, 1, 1, 0, 0, P_BR};
    vecs[3]  = '{1, 1, 0, 0, 0, P_BR};
    vecs[4]  = '{0, 0, 0, 0, 0, P_IWAIT};
    vecs[5]  = '{1, 0, 0, 0, 0, P_HZ};
    vecs[6]  = '{0, 0, 1, 1, 1, P_RUN};
    vecs[7]  = '{0, 1, 1, 1, 1, P_BR};
    vecs[8]  = '{1, 1, 1, 1, 0, P_DBUSY};
    vecs[9]  = '{0, 1, 1, 1, 1, P_BR};
    vecs[10] = '{0, 0, 1, 0, 0, P_RUN};

    // Bring DUT state out of X before the model is compared against it
    @(posedge clk);
    #1;

    // Reset values, then idle run
    do_reset();
    chk("idle_ctrl", {57'd0, act_ctrl[0]}, {57'd0, P_RUN});
    chk("idle_stall", act_stall[0], 64'd0);
    chk("idle_flush", act_flush[0], 64'd0);
    chk("idle_err", {63'd0, act_err[0]}, 64'd0);

    // Priority table
    for (int v = 0; v < 11; v++) begin
      set_in(vecs[v].hz, vecs[v].br, vecs[v].im, vecs[v].rq, vecs[v].rd);
      #1 chk($sformatf("vec%0d_ctrl", v), {57'd0, act_ctrl[0]}, {57'd0, vecs[v].exp});
      tick();
    end

    // Single load-use stall
    do_reset();
    set_in(1, 0, 1, 0, 0);
    #1 chk("hz_ctrl", {57'd0, act_ctrl[0]}, {57'd0, P_HZ});
    tick();
    set_in(0, 0, 1, 0, 0);
    chk("hz_stall_cnt", act_stall[0], 64'd1);

    // Branch overrides hazard
    do_reset();
    set_in(1, 1, 1, 0, 0);
    #1 chk("br_hz_ctrl", {57'd0, act_ctrl[0]}, {57'd0, P_BR});
    tick();
    set_in(0, 0, 1, 0, 0);
    chk("br_flush_cnt", act_flush[0], 64'd1);
    chk("br_stall_cnt", act_stall[0], 64'd0);

    // Data wait completing after 3 frozen cycles
    do_reset();
    set_in(0, 0, 1, 1, 0);
    for (int c = 0; c < 3; c++) begin
      #1 chk("dwait_ctrl", {57'd0, act_ctrl[0]}, {57'd0, P_DBUSY});
      tick();
    end
    chk("dwait_state", 64'(if_a.state_o), 64'(DWAIT));
    rd = 1'b1;
    #1 chk("dwait_done_ctrl", {57'd0, act_ctrl[0]}, {57'd0, P_RUN});
    tick();
    set_in(0, 0, 1, 0, 0);
    chk("dwait_stall_cnt", act_stall[0], 64'd3);
    chk("dwait_err", {63'd0, act_err[0]}, 64'd0);
    chk("dwait_back_run", 64'(if_a.state_o), 64'(RUN));

    // Timeout: 16 frozen cycles, release, sticky error
    do_reset();
    set_in(0, 0, 1, 1, 0);
    for (int c = 0; c < 16; c++) begin
      #1 chk("tmo_frozen", {57'd0, act_ctrl[0]}, {57'd0, P_DBUSY});
      tick();
    end
    #1 chk("tmo_release", {57'd0, act_ctrl[0]}, {57'd0, P_RUN});
    tick();
    set_in(0, 0, 1, 0, 0);
    chk("tmo_err_set", {63'd0, act_err[0]}, 64'd1);
    chk("tmo_stall_cnt", act_stall[0], 64'd16);
    set_in(0, 0, 1, 1, 0);
    tick();
    rd = 1'b1;
    tick();
    set_in(0, 0, 1, 0, 0);
    tick();
    chk("tmo_err_sticky", {63'd0, act_err[0]}, 64'd1);

    // Reset in the middle of a wait drops it without an error
    do_reset();
    set_in(0, 0, 1, 1, 0);
    tick();
    tick();
    do_reset();
    chk("rst_mid_wait_state", 64'(if_a.state_o), 64'(RUN));
    chk("rst_mid_wait_err", {63'd0, act_err[0]}, 64'd0);

    // Saturation of the 4-bit counters
    do_reset();
    set_in(1, 0, 1, 0, 0);
    for (int c = 0; c < 20; c++) tick();
    chk("sat_stall_b", act_stall[1], 64'd15);
    chk("sat_stall_a", act_stall[0], 64'd20);
    for (int c = 0; c < 3; c++) tick();
    chk("sat_stall_b_hold", act_stall[1], 64'd15);
    set_in(0, 1, 1, 0, 0);
    for (int c = 0; c < 18; c++) tick();
    chk("sat_flush_b", act_flush[1], 64'd15);

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      hz = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 5) == 0);
      im = ($urandom_range(0, 4) != 0);
      rq = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 6) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
